serial_frame_sender: RTL and testbench
======================================

Name: serial_frame_sender

Overview:
- Transmit end of the team's serial framing link. Accepts one parallel word over a start/ready handshake and shifts it out one bit per clock.
- Frame format: fixed start pattern, then payload MSB first, then an optional parity bit. The line idles high between frames.
- Drives the serial line read by the detect/collect/load/transmit receiver path.

Parameters:
- DATA_W, 8, payload width in bits (>=2)
- START_W, 4, start pattern width in bits (>=2)
- START_PAT, 4'b1101, start pattern, sent MSB first
- IDLE_LEVEL, 1'b1, serial_out level outside frames

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  frame request; accepted when start=1 and ready=1 on a rising edge
- data_in  input  DATA_W  payload word; sampled only on the accept edge
- ready  output  1  block is idle and can accept a request
- serial_out  output  1  serial line, registered
- sending  output  1  high on every cycle a frame bit is on serial_out
- done  output  1  one-cycle pulse after the last frame bit

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high. rst=1 at a rising edge dominates all other inputs.
- Reset values:
  - state=IDLE
  - ready=1
  - serial_out=IDLE_LEVEL
  - sending=0
  - done=0
  - shift register and bit counter = 0
- States: IDLE, PREAMBLE, PAYLOAD, PARITY (only with the optional feature), DONE.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- IDLE:
  - ready=1, sending=0, serial_out=IDLE_LEVEL.
  - On an edge with start=1: latch data_in into the shift register, clear the counter, go to PREAMBLE.
- PREAMBLE:
  - Lasts START_W cycles; serial_out=START_PAT[START_W-1-i] on cycle i.
  - sending=1, ready=0.
  - After the last pattern bit, go to PAYLOAD.
- PAYLOAD:
  - Lasts DATA_W cycles; serial_out=data[DATA_W-1-i] on cycle i (MSB first, left shift).
  - After the last bit, go to PARITY if enabled, otherwise DONE.
- DONE:
  - Lasts one cycle; done=1, sending=0, ready=0, serial_out=IDLE_LEVEL.
  - Next state is always IDLE.
- Timing, with the accept edge at cycle 0:
  - Cycles 1..START_W carry the pattern.
  - The next DATA_W cycles carry the payload.
  - done is high on cycle START_W+DATA_W+1 (+1 with parity).
  - ready returns high on the following cycle.
  - Defaults without parity: pattern on cycles 1-4, data on cycles 5-12, done on 13, ready on 14.
- start while ready=0, including the DONE cycle, is ignored and not queued. Back-to-back frames therefore have at least 2 idle-level cycles (DONE and one IDLE cycle) between them.
- data_in changes after the accept edge do not affect the frame in flight.
- The bit counter is sized ceil(log2(max(START_W,DATA_W)+1)), reloads at every state change and never wraps mid-state.
- rst mid-frame: on the next edge serial_out=IDLE_LEVEL, state=IDLE and ready=1. No done pulse, and the partial frame is abandoned.
- Undefined state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: SERIAL_FRAME_PARITY_EN.
- Defined:
  - A PARITY state follows PAYLOAD for one cycle.
  - serial_out = XOR of all DATA_W latched payload bits (even parity); sending=1.
  - The parity is computed at accept time and stored in a register.
  - Frame length grows by 1; all later timing shifts by 1 cycle.
- Undefined: the PARITY state and parity register are absent; PAYLOAD goes directly to DONE.

Test Plan:
- Reset idle: hold rst=1 for 3 cycles, then release with start=0 -> serial_out=1, ready=1, sending=0, done=0 on every cycle.
- Basic frame: data_in=8'hA5, start pulse at cycle 0 ->
  - serial_out cycles 1-12 = 1,1,0,1, 1,0,1,0,0,1,0,1
  - sending=1 on cycles 1-12
  - done=1 on cycle 13 only
  - ready=1 from cycle 14
- Ignored requests: start held high throughout with data_in changing every cycle ->
  - frame uses the cycle-0 value
  - the next frame is accepted on the first ready=1 edge (cycle 14)
  - exactly two idle-level cycles (13, 14) between frames
- Reset mid-frame: start a frame with 8'hFF, assert rst on cycle 7 ->
  - cycle 8: serial_out=1, ready=1
  - no done pulse
  - a new frame with 8'h00 then transmits correctly
- Parity (SERIAL_FRAME_PARITY_EN defined):
  - data 8'hA5 -> cycle 13 serial_out=0, done on cycle 14
  - data 8'h07 -> cycle 13 serial_out=1
- Parameter sweep: DATA_W=4, START_PAT=4'b1001, data 4'hC -> serial_out cycles 1-8 = 1,0,0,1,1,1,0,0; done on cycle 9.

Source files
------------

// File: rtl/serial_frame_sender.sv
// Serial frame transmitter: start pattern, payload MSB first, optional even parity bit.
// Optional parity bit enabled by defining SERIAL_FRAME_PARITY_EN.
module serial_frame_sender #(
    parameter int unsigned          DATA_W     = 8,
    parameter int unsigned          START_W    = 4,
    parameter logic [START_W-1:0]   START_PAT  = 4'b1101,
    parameter logic                 IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              serial_out,
    output logic              sending,
    output logic              done
);

    localparam int unsigned MAX_W = (START_W > DATA_W) ? START_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_DONE     = 3'd4
`ifdef SERIAL_FRAME_PARITY_EN
        , S_PARITY = 3'd3
`endif
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  shift_q;
    logic [START_W-1:0] pat_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               ser_q;
    logic               sending_q;
    logic               done_q;
`ifdef SERIAL_FRAME_PARITY_EN
    logic               par_q;
`endif

    // Outputs are loaded one edge ahead with the value of the bit the next state presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            pat_q     <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            ser_q     <= IDLE_LEVEL;
            sending_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q   <= 1'b1;
                    sending_q <= 1'b0;
                    ser_q     <= IDLE_LEVEL;
                    if (start) begin
                        state_q   <= S_PREAMBLE;
                        shift_q   <= data_in;
                        pat_q     <= START_PAT << 1;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        sending_q <= 1'b1;
                        ser_q     <= START_PAT[START_W-1];
`ifdef SERIAL_FRAME_PARITY_EN
                        par_q     <= ^data_in;
`endif
                    end
                end
                S_PREAMBLE: begin
                    if (cnt_q == CNT_W'(START_W - 1)) begin
                        state_q <= S_PAYLOAD;
                        cnt_q   <= '0;
                        ser_q   <= shift_q[DATA_W-1];
                        shift_q <= shift_q << 1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        ser_q   <= pat_q[START_W-1];
                        pat_q   <= pat_q << 1;
                    end
                end
                S_PAYLOAD: begin
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_q     <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
                        state_q   <= S_PARITY;
                        ser_q     <= par_q;
`else
                        state_q   <= S_DONE;
                        ser_q     <= IDLE_LEVEL;
                        sending_q <= 1'b0;
                        done_q    <= 1'b1;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        ser_q   <= shift_q[DATA_W-1];
                        shift_q <= shift_q << 1;
                    end
                end
`ifdef SERIAL_FRAME_PARITY_EN
                S_PARITY: begin
                    state_q   <= S_DONE;
                    ser_q     <= IDLE_LEVEL;
                    sending_q <= 1'b0;
                    done_q    <= 1'b1;
                end
`endif
                S_DONE: begin
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b1;
                    ser_q     <= IDLE_LEVEL;
                    sending_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= '0;
                    ready_q   <= 1'b1;
                    ser_q     <= IDLE_LEVEL;
                    sending_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign serial_out = ser_q;
    assign sending    = sending_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_frame_sender.sv
// Scoreboard bench for serial_frame_sender: default instance plus a DATA_W=4 / START_PAT=1001 instance.
module tb_serial_frame_sender;

    typedef struct {
        int   cyc;
        logic rdy;
        logic ser;
        logic snd;
        logic dn;
    } exp_t;

`ifdef SERIAL_FRAME_PARITY_EN
    localparam int FL  = 13;
    localparam int FL4 = 9;
`else
    localparam int FL  = 12;
    localparam int FL4 = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, serial_out, sending, done;
    logic       start4 = 1'b0;
    logic [3:0] data4 = 4'h0;
    logic       ready4, serial4, sending4, done4;

    int cyc = 0;
    int compared = 0;
    int mism = 0;
    exp_t q0[$];
    exp_t q1[$];

    serial_frame_sender u_dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .ready(ready), .serial_out(serial_out), .sending(sending), .done(done)
    );

    serial_frame_sender #(.DATA_W(4), .START_W(4), .START_PAT(4'b1001)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .data_in(data4),
        .ready(ready4), .serial_out(serial4), .sending(sending4), .done(done4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_e(input int id, input int c, input logic rdy, ser, snd, dn);
        exp_t e;
        e.cyc = c; e.rdy = rdy; e.ser = ser; e.snd = snd; e.dn = dn;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // Expected windows c0+1.. for a frame accepted at the end of window c0, up to window c0+last.
    task automatic push_frame(input int id, input int c0, input logic [15:0] bits,
                              input int nb, input logic par, input int last);
        int n;
        n = nb;
        for (int i = 1; i <= nb; i++)
            if (i <= last) push_e(id, c0 + i, 1'b0, bits[nb - i], 1'b1, 1'b0);
`ifdef SERIAL_FRAME_PARITY_EN
        n = nb + 1;
        if (n <= last) push_e(id, c0 + n, 1'b0, par, 1'b1, 1'b0);
`else
        if (par === 1'bz) n = nb;
`endif
        if (n + 1 <= last) push_e(id, c0 + n + 1, 1'b0, 1'b1, 1'b0, 1'b1);
        if (n + 2 <= last) push_e(id, c0 + n + 2, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic cmp(input int id, input string nm, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mism++;
            $display("FAIL dut%0d %s cyc=%0d got=%b exp=%b", id, nm, cyc, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic rdy, ser, snd, dn);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (id == 0) begin
            if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
        end
        if (have) begin
            if (e.cyc != cyc) begin
                compared++; mism++;
                $display("FAIL dut%0d missed_window got_cyc=%0d exp_cyc=%0d", id, cyc, e.cyc);
            end else begin
                cmp(id, "ready", rdy, e.rdy);
                cmp(id, "serial_out", ser, e.ser);
                cmp(id, "sending", snd, e.snd);
                cmp(id, "done", dn, e.dn);
            end
        end else if (snd === 1'b1 || dn === 1'b1) begin
            compared++; mism++;
            $display("FAIL dut%0d unexpected_output cyc=%0d got sending=%b done=%b exp none",
                     id, cyc, snd, dn);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            mon(0, ready, serial_out, sending, done);
            mon(1, ready4, serial4, sending4, done4);
        end
    end

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int c0, c1, c2, c3, guard;
        // Reset held for three edges, then idle.
        for (int c = 1; c <= 6; c++) begin
            push_e(0, c, 1'b1, 1'b1, 1'b0, 1'b0);
            push_e(1, c, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        go(3);
        rst = 1'b0;

        // Basic frame A5 on both instances; narrow instance sends C with pattern 1001.
        c0 = 8;
        go(c0);
        push_frame(0, c0, 16'b0000_1101_1010_0101, 12, 1'b0, 99);
        push_frame(1, c0, 16'b0000_0000_1001_1100, 8, 1'b0, 99);
        start = 1'b1; data_in = 8'hA5;
        start4 = 1'b1; data4 = 4'hC;
        go(c0 + 1);
        start = 1'b0; data_in = 8'h00;
        start4 = 1'b0; data4 = 4'h3;

        // start held high, data scrambled: first frame keeps 3C, second accepts 5A.
        c1 = c0 + FL + 6;
        go(c1);
        push_frame(0, c1, 16'b0000_1101_0011_1100, 12, 1'b0, 99);
        start = 1'b1; data_in = 8'h3C;
        for (int k = 1; k <= FL + 1; k++) begin
            go(c1 + k);
            data_in = 8'($urandom);
        end
        c2 = c1 + FL + 2;
        go(c2);
        data_in = 8'h5A;
        push_frame(0, c2, 16'b0000_1101_0101_1010, 12, 1'b0, 99);
        go(c2 + 1);
        start = 1'b0;

        // Reset mid-frame: FF frame cut after window 7, no done pulse.
        c3 = c2 + FL + 4;
        go(c3);
        push_frame(0, c3, 16'b0000_1101_1111_1111, 12, 1'b0, 7);
        for (int c = 8; c <= 10; c++) push_e(0, c3 + c, 1'b1, 1'b1, 1'b0, 1'b0);
        start = 1'b1; data_in = 8'hFF;
        go(c3 + 1);
        start = 1'b0;
        go(c3 + 7);
        rst = 1'b1;
        go(c3 + 8);
        rst = 1'b0;

        // Recovery frame 00, then 07 (odd parity count).
        c0 = c3 + 11;
        go(c0);
        push_frame(0, c0, 16'b0000_1101_0000_0000, 12, 1'b0, 99);
        start = 1'b1; data_in = 8'h00;
        go(c0 + 1);
        start = 1'b0;
        c1 = c0 + FL + 4;
        go(c1);
        push_frame(0, c1, 16'b0000_1101_0000_0111, 12, 1'b1, 99);
        start = 1'b1; data_in = 8'h07;
        go(c1 + 1);
        start = 1'b0;
        go(c1 + FL + 5);

        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 50) begin
            @(posedge clk);
            #2;
            guard++;
        end
        compared++;
        if (q0.size() != 0 || q1.size() != 0) begin
            mism++;
            $display("FAIL drain got=%0d/%0d pending exp=0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
